unsmoothing_filter: RTL

- Inverse of the 4-tap moving-average smoothing filter. It takes the stream of smoothed samples and rebuilds the quantised input samples (x>>2)<<2.
- Sits downstream of the link or storage that carries the smoothed stream, so the original sample shape can be checked and displayed.
- Recurrence: q(n) = s(n) - s(n-1) + q(n-4); output = q(n) << SHIFT.
- Detects loss of lock with the upstream filter and flags it.

---
 rtl/unsmoothing_filter.sv | 114 +++++++++++
 1 files changed

// File: rtl/unsmoothing_filter.sv
// unsmoothing_filter: rebuilds quantised samples from a TAPS-tap moving-average stream; define UNSMOOTH_SAT_EN to clamp out-of-range results
module unsmoothing_filter #(
    parameter int DATA_W = 8,
    parameter int TAPS   = 4,
    parameter int SHIFT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enb,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              err,
    input  logic              err_clr
);
    localparam int QW = DATA_W - SHIFT;

    typedef enum logic {RUN, DESYNC} state_t;

    state_t                   state_q, state_d;
    logic [DATA_W-1:0]        s_prev_q, s_prev_d;
    logic signed [DATA_W:0]   d1_q, d1_d;
    logic                     v1_q, v1_d;
    logic [QW-1:0]            q_hist_q [TAPS];
    logic [QW-1:0]            q_hist_d [TAPS];
    logic [DATA_W-1:0]        out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;

    logic                     adv2, acc, oor;
    logic signed [DATA_W:0]   d;
    logic signed [DATA_W+1:0] qf;
    logic [QW-1:0]            q;

    // handshakes, first difference, and the reconstructed sample with its range check
    always_comb begin
        adv2 = enb & v1_q & (~out_valid_q | out_ready);
        in_ready = ~v1_q | adv2;
        acc = enb & in_valid & in_ready & ~err_clr;
        d = {1'b0, in_data} - {1'b0, s_prev_q};
        qf = {d1_q[DATA_W], d1_q} + {{(DATA_W + 2 - QW){1'b0}}, q_hist_q[TAPS-1]};
        oor = qf[DATA_W+1] | (qf[DATA_W:QW] != '0);
`ifdef UNSMOOTH_SAT_EN
        q = qf[DATA_W+1] ? '0 : oor ? '1 : qf[QW-1:0];
`else
        q = qf[QW-1:0];
`endif
    end

    // datapath next state: err_clr flushes everything, otherwise stage 2 drains before stage 1 refills
    always_comb begin
        s_prev_d    = s_prev_q;
        d1_d        = d1_q;
        v1_d        = v1_q;
        q_hist_d    = q_hist_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        if (enb && err_clr) begin
            s_prev_d    = '0;
            v1_d        = 1'b0;
            q_hist_d    = '{default: '0};
            out_valid_d = 1'b0;
        end else if (enb) begin
            if (out_valid_q && out_ready)
                out_valid_d = 1'b0;
            if (adv2) begin
                v1_d = 1'b0;
                for (int i = TAPS - 1; i > 0; i--)
                    q_hist_d[i] = q_hist_q[i-1];
                q_hist_d[0] = q;
                out_data_d  = {q, {SHIFT{1'b0}}};
                out_valid_d = 1'b1;
            end
            if (acc) begin
                s_prev_d = in_data;
                d1_d     = d;
                v1_d     = 1'b1;
            end
        end
    end

    // lock tracking: any out-of-range reconstruction latches DESYNC until err_clr
    always_comb begin
        state_d = !enb ? state_q : err_clr ? RUN : (adv2 && oor) ? DESYNC : state_q;
    end

    // state registers; reset zero state matches the upstream filter's reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            s_prev_q    <= '0;
            d1_q        <= '0;
            v1_q        <= 1'b0;
            q_hist_q    <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_prev_q    <= s_prev_d;
            d1_q        <= d1_d;
            v1_q        <= v1_d;
            q_hist_q    <= q_hist_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign err       = (state_q == DESYNC);

endmodule
